// File: rtl/peak_alarm.sv
// Hysteresis alarm on windowed peak values with per-window debounce, event count and running max.
// Optional PEAK_ALARM_TIMESTAMP_EN adds a window counter and the window index of the last alarm rise.
module peak_alarm #(
  parameter int DWIDTH      = 16,
  parameter int ASSERT_CNT  = 3,
  parameter int RELEASE_CNT = 3,
  parameter int CWIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DWIDTH-1:0] peak,
  input  logic                     peak_stb,
  input  logic signed [DWIDTH-1:0] thr_hi,
  input  logic signed [DWIDTH-1:0] thr_lo,
  input  logic                     clr,
  output logic                     alarm,
  output logic                     alarm_rise,
  output logic                     alarm_fall,
  output logic [CWIDTH-1:0]        evt_cnt,
`ifdef PEAK_ALARM_TIMESTAMP_EN
  output logic [31:0]              win_cnt,
  output logic [31:0]              alarm_ts,
`endif
  output logic signed [DWIDTH-1:0] peak_max
);

  localparam int AW = (ASSERT_CNT  < 2) ? 1 : $clog2(ASSERT_CNT + 1);
  localparam int RW = (RELEASE_CNT < 2) ? 1 : $clog2(RELEASE_CNT + 1);
  localparam logic [AW-1:0] ACNT_MAX = AW'(ASSERT_CNT);
  localparam logic [RW-1:0] RCNT_MAX = RW'(RELEASE_CNT);
  localparam logic signed [DWIDTH-1:0] PEAK_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ARMING, S_ALARM, S_RELEASING} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_acnt, w_acnt_nxt;
  logic [RW-1:0]   r_rcnt, w_rcnt_nxt;
  logic            r_alarm, r_rise, r_fall;
  logic            w_alarm_nxt, w_rise, w_fall;
  logic            w_above, w_below;
  logic [CWIDTH-1:0]        r_evt_cnt;
  logic signed [DWIDTH-1:0] r_peak_max;

  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_above = (peak >= thr_hi);
  assign w_below = (peak <  thr_lo);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acnt  <= '0;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acnt  <= w_acnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  // IDLE/ARMING only look at "above", ALARM/RELEASING only at "below"
  always_comb begin
    w_state_nxt = r_state;
    w_acnt_nxt  = r_acnt;
    w_rcnt_nxt  = r_rcnt;
    if (peak_stb) begin
      case (r_state)
        S_IDLE: begin
          if (w_above) begin
            if (ASSERT_CNT == 1) begin
              w_state_nxt = S_ALARM;
            end else begin
              w_state_nxt = S_ARMING;
              w_acnt_nxt  = AW'(1);
            end
          end
        end
        S_ARMING: begin
          if (w_above) begin
            if (r_acnt + 1'b1 == ACNT_MAX) begin
              w_state_nxt = S_ALARM;
              w_acnt_nxt  = '0;
            end else begin
              w_acnt_nxt  = r_acnt + 1'b1;
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_acnt_nxt  = '0;
          end
        end
        S_ALARM: begin
          if (w_below) begin
            if (RELEASE_CNT == 1) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_RELEASING;
              w_rcnt_nxt  = RW'(1);
            end
          end
        end
        S_RELEASING: begin
          if (w_below) begin
            if (r_rcnt + 1'b1 == RCNT_MAX) begin
              w_state_nxt = S_IDLE;
              w_rcnt_nxt  = '0;
            end else begin
              w_rcnt_nxt  = r_rcnt + 1'b1;
            end
          end else begin
            w_state_nxt = S_ALARM;
            w_rcnt_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_acnt_nxt  = '0;
          w_rcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_alarm_nxt = (w_state_nxt == S_ALARM) || (w_state_nxt == S_RELEASING);
    w_rise      = w_alarm_nxt & ~r_alarm;
    w_fall      = ~w_alarm_nxt & r_alarm;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alarm <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_alarm <= w_alarm_nxt;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
    end
  end

  // clr takes priority over a coincident strobe or rise for the statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_evt_cnt  <= '0;
      r_peak_max <= PEAK_MIN;
    end else if (clr) begin
      r_evt_cnt  <= '0;
      r_peak_max <= PEAK_MIN;
    end else begin
      if (w_rise)
        r_evt_cnt <= sat_inc(r_evt_cnt);
      if (peak_stb && (peak > r_peak_max))
        r_peak_max <= peak;
    end
  end

`ifdef PEAK_ALARM_TIMESTAMP_EN
  logic [31:0] r_win_cnt, r_alarm_ts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_cnt  <= '0;
      r_alarm_ts <= '0;
    end else begin
      if (peak_stb)
        r_win_cnt <= r_win_cnt + 32'd1;
      if (w_rise)
        r_alarm_ts <= r_win_cnt;
    end
  end

  assign win_cnt  = r_win_cnt;
  assign alarm_ts = r_alarm_ts;
`endif

  assign alarm      = r_alarm;
  assign alarm_rise = r_rise;
  assign alarm_fall = r_fall;
  assign evt_cnt    = r_evt_cnt;
  assign peak_max   = r_peak_max;

endmodule

// File: tb/tb_peak_alarm.sv
// Directed bench for peak_alarm: debounce, hysteresis, saturation, clr priority, signed max, gaps, reset.
module tb_peak_alarm;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] peak = '0;
  logic               peak_stb = 1'b0;
  logic signed [15:0] thr_hi = 16'sd1000;
  logic signed [15:0] thr_lo = 16'sd500;
  logic               clr = 1'b0;
  logic               alarm, alarm_rise, alarm_fall;
  logic [1:0]         evt_cnt;
  logic signed [15:0] peak_max;
`ifdef PEAK_ALARM_TIMESTAMP_EN
  logic [31:0]        win_cnt, alarm_ts;
`endif

  int n_cmp = 0;
  int n_err = 0;

  peak_alarm #(.DWIDTH(16), .ASSERT_CNT(3), .RELEASE_CNT(3), .CWIDTH(2)) dut (
    .clk(clk), .rst(rst), .peak(peak), .peak_stb(peak_stb),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .clr(clr),
    .alarm(alarm), .alarm_rise(alarm_rise), .alarm_fall(alarm_fall),
    .evt_cnt(evt_cnt),
`ifdef PEAK_ALARM_TIMESTAMP_EN
    .win_cnt(win_cnt), .alarm_ts(alarm_ts),
`endif
    .peak_max(peak_max)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; returns at the next falling edge with the result visible.
  task automatic stb(input logic signed [15:0] p);
    peak = p;
    peak_stb = 1'b1;
    @(negedge clk);
    peak_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    idle(3);
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL rst_alarm got=%b exp=0", alarm); end
    rst = 1'b1;
    idle(1);
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL rel_alarm got=%b exp=0", alarm); end
    n_cmp++; if (alarm_rise !== 1'b0 || alarm_fall !== 1'b0) begin n_err++; $display("FAIL rel_pulses got=%b%b exp=00", alarm_rise, alarm_fall); end
    n_cmp++; if (evt_cnt !== 2'd0) begin n_err++; $display("FAIL rel_evt got=%0d exp=0", evt_cnt); end
    n_cmp++; if (peak_max !== 16'sh8000) begin n_err++; $display("FAIL rel_pmax got=%h exp=8000", peak_max); end
  endtask

  task automatic test_assert_debounce;
    stb(16'sd1200);
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL deb1_alarm got=%b exp=0", alarm); end
    stb(16'sd1100);
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL deb2_alarm got=%b exp=0", alarm); end
    stb(16'sd1000);
    n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL deb3_alarm got=%b exp=1", alarm); end
    n_cmp++; if (alarm_rise !== 1'b1) begin n_err++; $display("FAIL deb3_rise got=%b exp=1", alarm_rise); end
    n_cmp++; if (evt_cnt !== 2'd1) begin n_err++; $display("FAIL deb3_evt got=%0d exp=1", evt_cnt); end
    idle(1);
    n_cmp++; if (alarm_rise !== 1'b0 || alarm !== 1'b1) begin n_err++; $display("FAIL deb_hold got=rise%b alarm%b exp=rise0 alarm1", alarm_rise, alarm); end
    n_cmp++; if (peak_max !== 16'sd1200) begin n_err++; $display("FAIL deb_pmax got=%0d exp=1200", peak_max); end
  endtask

  task automatic test_hysteresis;
    stb(16'sd700);
    stb(16'sd499);
    n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL hys499_alarm got=%b exp=1", alarm); end
    stb(16'sd600);
    n_cmp++; if (alarm !== 1'b1 || alarm_fall !== 1'b0) begin n_err++; $display("FAIL hys600 got=alarm%b fall%b exp=alarm1 fall0", alarm, alarm_fall); end
    stb(-16'sd300);
    stb(-16'sd300);
    n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL rel2_alarm got=%b exp=1", alarm); end
    stb(-16'sd300);
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL rel3_alarm got=%b exp=0", alarm); end
    n_cmp++; if (alarm_fall !== 1'b1) begin n_err++; $display("FAIL rel3_fall got=%b exp=1", alarm_fall); end
    idle(1);
    n_cmp++; if (alarm_fall !== 1'b0) begin n_err++; $display("FAIL rel_fall_width got=%b exp=0", alarm_fall); end
  endtask

  task automatic test_interrupted;
    logic signed [15:0] seq [4] = '{16'sd1200, 16'sd1200, 16'sd900, 16'sd1200};
    for (int i = 0; i < 4; i++) begin
      stb(seq[i]);
      n_cmp++; if (alarm !== 1'b0 || alarm_rise !== 1'b0) begin n_err++; $display("FAIL intr%0d got=alarm%b rise%b exp=00", i, alarm, alarm_rise); end
    end
    stb(16'sd0);
    n_cmp++; if (evt_cnt !== 2'd1) begin n_err++; $display("FAIL intr_evt got=%0d exp=1", evt_cnt); end
  endtask

  task automatic test_signed_peak_max;
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    n_cmp++; if (peak_max !== 16'sh8000 || evt_cnt !== 2'd0) begin n_err++; $display("FAIL clr got=pmax%h evt%0d exp=8000 0", peak_max, evt_cnt); end
    stb(-16'sd5);
    n_cmp++; if (peak_max !== -16'sd5) begin n_err++; $display("FAIL pmax_m5 got=%0d exp=-5", peak_max); end
    stb(-16'sd2);
    stb(-16'sd9);
    n_cmp++; if (peak_max !== -16'sd2) begin n_err++; $display("FAIL pmax_m2 got=%0d exp=-2", peak_max); end
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL neg_alarm got=%b exp=0", alarm); end
  endtask

  task automatic test_saturation_clr;
    logic [1:0] exp_e;
    for (int k = 1; k <= 5; k++) begin
      repeat (3) stb(16'sd1200);
      exp_e = (k > 3) ? 2'd3 : 2'(k);
      n_cmp++; if (evt_cnt !== exp_e) begin n_err++; $display("FAIL sat%0d got=%0d exp=%0d", k, evt_cnt, exp_e); end
      repeat (3) stb(-16'sd300);
    end
    stb(16'sd2000);
    stb(16'sd2000);
    peak = 16'sd2000; peak_stb = 1'b1; clr = 1'b1;
    @(negedge clk);
    peak_stb = 1'b0; clr = 1'b0;
    n_cmp++; if (alarm !== 1'b1 || alarm_rise !== 1'b1) begin n_err++; $display("FAIL clrstb_fsm got=alarm%b rise%b exp=11", alarm, alarm_rise); end
    n_cmp++; if (evt_cnt !== 2'd0) begin n_err++; $display("FAIL clrstb_evt got=%0d exp=0", evt_cnt); end
    n_cmp++; if (peak_max !== 16'sh8000) begin n_err++; $display("FAIL clrstb_pmax got=%h exp=8000", peak_max); end
    repeat (3) stb(-16'sd300);
    n_cmp++; if (alarm !== 1'b0 || alarm_fall !== 1'b1) begin n_err++; $display("FAIL clrstb_rel got=alarm%b fall%b exp=01", alarm, alarm_fall); end
  endtask

  task automatic test_gaps;
    for (int g = 0; g <= 100; g += 100) begin
      for (int i = 0; i < 3; i++) begin
        stb(16'sd1500);
        idle(g);
      end
      n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL gap%0d_on got=%b exp=1", g, alarm); end
      for (int i = 0; i < 3; i++) begin
        stb(16'sd100);
        idle(g);
      end
      n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL gap%0d_off got=%b exp=0", g, alarm); end
    end
    n_cmp++; if (evt_cnt !== 2'd2) begin n_err++; $display("FAIL gap_evt got=%0d exp=2", evt_cnt); end
  endtask

  task automatic test_reset_midop;
    repeat (3) stb(16'sd1500);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (alarm !== 1'b0 || alarm_fall !== 1'b0) begin n_err++; $display("FAIL mid_rst got=alarm%b fall%b exp=00", alarm, alarm_fall); end
    n_cmp++; if (evt_cnt !== 2'd0 || peak_max !== 16'sh8000) begin n_err++; $display("FAIL mid_rst_stat got=evt%0d pmax%h exp=0 8000", evt_cnt, peak_max); end
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    n_cmp++; if (alarm_fall !== 1'b0) begin n_err++; $display("FAIL mid_rst_nofall got=%b exp=0", alarm_fall); end
  endtask

  initial begin
    test_reset();
    test_assert_debounce();
    test_hysteresis();
    test_interrupted();
    test_signed_peak_max();
    test_saturation_clr();
    test_gaps();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
